scm_load_ctrl: RTL and testbench



---
 rtl/scm_pkg.sv | 27 ++
 rtl/scm_load_ctrl.sv | 147 ++++++++++++++
 tb/tb_scm_load_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scm_pkg.sv
// +----------------------------------------------------------------------------
// | scm_pkg : shared defaults, types and controller state encoding for the SCM LUT
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package scm_pkg;

  localparam int DEFAULT_C          = 32;
  localparam int DEFAULT_K          = 16;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_C * DEFAULT_K);

  typedef logic        [DEFAULT_ADDR_WIDTH-1:0] scm_addr_t;
  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] scm_data_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GAP    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_READY  = 3'd4
  } scm_ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/scm_load_ctrl.sv
// +----------------------------------------------------------------------------
// | scm_load_ctrl : sequences LUT loads into the latch-based scm and serves reads
// | Option: SCM_LOAD_CTRL_BACK_TO_BACK_EN removes the GAP cycle between writes
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module scm_load_ctrl #(
  parameter int C              = scm_pkg::DEFAULT_C,
  parameter int K              = scm_pkg::DEFAULT_K,
  parameter int DataTypeWidth  = scm_pkg::DEFAULT_DATA_WIDTH,
  parameter int TotalAddrWidth = $clog2(C * K)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [DataTypeWidth-1:0]  load_data_i,
  output logic                      lut_valid_o,
  output logic                      busy_o,
  input  logic                      rd_req_valid_i,
  output logic                      rd_req_ready_o,
  input  logic [TotalAddrWidth-1:0] rd_addr_i,
  output logic                      rd_rsp_valid_o,
  output logic [DataTypeWidth-1:0]  rd_rsp_data_o,
  output logic                      rd_rsp_err_o,
  output logic [TotalAddrWidth-1:0] scm_waddr_o,
  output logic [DataTypeWidth-1:0]  scm_wdata_o,
  output logic                      scm_we_o,
  output logic [TotalAddrWidth-1:0] scm_raddr_o,
  input  logic [DataTypeWidth-1:0]  scm_rdata_i
);

  import scm_pkg::*;

  localparam logic [TotalAddrWidth:0] c_DEPTH    = (TotalAddrWidth+1)'(C * K);
  localparam logic [TotalAddrWidth:0] c_LAST_IDX = (TotalAddrWidth+1)'(C * K - 1);
  localparam logic [TotalAddrWidth:0] c_ONE      = (TotalAddrWidth+1)'(1);

  scm_ctrl_state_e             r_state;
  scm_ctrl_state_e             w_state_nxt;
  logic [TotalAddrWidth:0]     r_cnt;
  logic                        r_we;
  logic [TotalAddrWidth-1:0]   r_waddr;
  logic [DataTypeWidth-1:0]    r_wdata;
  logic                        r_rsp_valid;
  logic [DataTypeWidth-1:0]    r_rsp_data;
  logic                        r_rsp_err;

  logic w_load_hs;
  logic w_rd_hs;
  logic w_last;
  logic w_rd_err;
  logic w_restart;

  assign w_load_hs = (r_state == ST_LOAD) && load_valid_i;
  assign w_rd_hs   = (r_state == ST_READY) && rd_req_valid_i;
  assign w_last    = (r_cnt == c_LAST_IDX);
  assign w_restart = ((r_state == ST_IDLE) || (r_state == ST_READY)) && start_i;
  // Only reachable when C*K is not a power of two.
  assign w_rd_err  = ({1'b0, rd_addr_i} >= c_DEPTH);

  always_comb begin
    w_state_nxt    = r_state;
    load_ready_o   = 1'b0;
    busy_o         = 1'b0;
    lut_valid_o    = 1'b0;
    rd_req_ready_o = 1'b0;
    scm_raddr_o    = '0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (w_load_hs) begin
          if (w_last) begin
            w_state_nxt = ST_SETTLE;
          end else begin
`ifdef SCM_LOAD_CTRL_BACK_TO_BACK_EN
            w_state_nxt = ST_LOAD;
`else
            w_state_nxt = ST_GAP;
`endif
          end
        end
      end
      ST_GAP: begin
        busy_o      = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_SETTLE: begin
        busy_o      = 1'b1;
        w_state_nxt = ST_READY;
      end
      ST_READY: begin
        lut_valid_o    = 1'b1;
        rd_req_ready_o = 1'b1;
        scm_raddr_o    = rd_addr_i;
        if (start_i) w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_cnt <= '0;
      end else if (w_load_hs) begin
        r_cnt <= r_cnt + c_ONE;
      end
      r_we <= w_load_hs;
      if (w_load_hs) begin
        r_waddr <= r_cnt[TotalAddrWidth-1:0];
        r_wdata <= load_data_i;
      end
      r_rsp_valid <= w_rd_hs;
      if (w_rd_hs) begin
        r_rsp_err  <= w_rd_err;
        r_rsp_data <= w_rd_err ? '0 : scm_rdata_i;
      end
    end
  end

  assign scm_we_o       = r_we;
  assign scm_waddr_o    = r_waddr;
  assign scm_wdata_o    = r_wdata;
  assign rd_rsp_valid_o = r_rsp_valid;
  assign rd_rsp_data_o  = r_rsp_data;
  assign rd_rsp_err_o   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_scm_load_ctrl.sv
// +----------------------------------------------------------------------------
// | tb_scm_load_ctrl : directed self-checking bench for scm_load_ctrl
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_scm_load_ctrl;
  import scm_pkg::*;

  localparam int DW      = DEFAULT_DATA_WIDTH;
  localparam int AW      = DEFAULT_ADDR_WIDTH;
  localparam int DEPTH   = DEFAULT_C * DEFAULT_K;
  localparam int S_AW    = 3;
`ifdef SCM_LOAD_CTRL_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (default 32x16 table)
  logic          start = 1'b0, load_valid = 1'b0, rd_req_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          load_ready, lut_valid, busy, rd_req_ready, rd_rsp_valid, rd_rsp_err, scm_we;
  logic [DW-1:0] rd_rsp_data, scm_wdata, scm_rdata;
  logic [AW-1:0] scm_waddr, scm_raddr;
  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) if (scm_we) mem[scm_waddr] <= scm_wdata;
  assign scm_rdata = mem[scm_raddr];

  scm_load_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .load_valid_i(load_valid), .load_ready_o(load_ready), .load_data_i(load_data),
    .lut_valid_o(lut_valid), .busy_o(busy),
    .rd_req_valid_i(rd_req_valid), .rd_req_ready_o(rd_req_ready), .rd_addr_i(rd_addr),
    .rd_rsp_valid_o(rd_rsp_valid), .rd_rsp_data_o(rd_rsp_data), .rd_rsp_err_o(rd_rsp_err),
    .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata), .scm_we_o(scm_we),
    .scm_raddr_o(scm_raddr), .scm_rdata_i(scm_rdata)
  );

  // small instance (2x3 = 6 entries) so out-of-range addresses are representable
  logic            s_start = 1'b0, s_load_valid = 1'b1, s_rd_req_valid = 1'b0;
  logic [DW-1:0]   s_load_data;
  logic [S_AW-1:0] s_rd_addr = '0;
  logic            s_load_ready, s_lut_valid, s_busy, s_rd_req_ready, s_rd_rsp_valid, s_rd_rsp_err, s_scm_we;
  logic [DW-1:0]   s_rd_rsp_data, s_scm_wdata, s_scm_rdata;
  logic [S_AW-1:0] s_scm_waddr, s_scm_raddr;
  logic [DW-1:0]   s_mem [8];
  int              s_cnt = 0;

  always @(posedge clk) if (s_scm_we) s_mem[s_scm_waddr] <= s_scm_wdata;
  always @(posedge clk) if (s_load_ready && s_load_valid) s_cnt <= s_cnt + 1;
  assign s_scm_rdata = s_mem[s_scm_raddr];
  assign s_load_data = DW'(10 + s_cnt);

  scm_load_ctrl #(.C(2), .K(3), .DataTypeWidth(DW)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start),
    .load_valid_i(s_load_valid), .load_ready_o(s_load_ready), .load_data_i(s_load_data),
    .lut_valid_o(s_lut_valid), .busy_o(s_busy),
    .rd_req_valid_i(s_rd_req_valid), .rd_req_ready_o(s_rd_req_ready), .rd_addr_i(s_rd_addr),
    .rd_rsp_valid_o(s_rd_rsp_valid), .rd_rsp_data_o(s_rd_rsp_data), .rd_rsp_err_o(s_rd_rsp_err),
    .scm_waddr_o(s_scm_waddr), .scm_wdata_o(s_scm_wdata), .scm_we_o(s_scm_we),
    .scm_raddr_o(s_scm_raddr), .scm_rdata_i(s_scm_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] main_outs();
    return 64'({load_ready, lut_valid, busy, rd_req_ready, rd_rsp_valid, rd_rsp_data,
                rd_rsp_err, scm_waddr, scm_wdata, scm_we, scm_raddr});
  endfunction

  function automatic logic [63:0] small_outs();
    return 64'({s_load_ready, s_lut_valid, s_busy, s_rd_req_ready, s_rd_rsp_valid, s_rd_rsp_data,
                s_rd_rsp_err, s_scm_waddr, s_scm_wdata, s_scm_we, s_scm_raddr});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams n words (value = addr or -addr) with valid held high; optional start_i pulse mid-load.
  task automatic run_load(input bit neg, input int n_words, input int start_at);
    int idx = 0, edges = 0, first = -1, last = -1, we_cnt = 0, bad = 0;
    bit hs, prev_we = 1'b0, started = 1'b0;
    logic [DW-1:0] exp_d;
    load_valid   = 1'b1;
    rd_req_valid = 1'b1;
    rd_addr      = AW'(5);
    while (idx < n_words && edges < 4 * n_words + 8) begin
      load_data = neg ? DW'(-idx) : DW'(idx);
      start     = (idx == start_at) && !started;
      if (start) started = 1'b1;
      #1;
      hs = load_ready && load_valid;
      if (rd_req_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick();
      start = 1'b0;
      edges++;
      if (hs) begin
        if (first < 0) first = edges;
        last = edges;
        idx++;
      end
      if (scm_we !== hs) bad++;
      if (hs) begin
        exp_d = neg ? DW'(-(idx - 1)) : DW'(idx - 1);
        if (scm_waddr !== AW'(idx - 1) || scm_wdata !== exp_d) bad++;
      end
      if (scm_we) we_cnt++;
      if (!B2B && prev_we && scm_we) bad++;
      if (rd_rsp_valid !== 1'b0) bad++;
      prev_we = scm_we;
    end
    load_valid   = 1'b0;
    rd_req_valid = 1'b0;
    check("load_words_accepted", 64'(idx), 64'(n_words));
    check("load_stream_errors", 64'(bad), 64'(0));
    check("load_we_count", 64'(we_cnt), 64'(n_words));
    check("load_hs_span", 64'(last - first + 1), 64'(B2B ? n_words : 2 * n_words - 1));
    if (n_words == DEPTH) begin
      check("settle_cycle", 64'({lut_valid, busy}), 64'(2'b01));
      tick();
      check("ready_after_settle", 64'({lut_valid, busy, rd_req_ready}), 64'(3'b101));
    end
  endtask

  typedef struct {
    int            phase;
    int            sel;
    int            addr;
    logic [DW-1:0] data;
    logic          err;
  } rd_vec_t;

  rd_vec_t vecs[$];

  task automatic do_read(input rd_vec_t v);
    string tag;
    tag = $sformatf("p%0d_dut%0d_a%0d", v.phase, v.sel, v.addr);
    if (v.sel == 0) begin
      rd_addr = AW'(v.addr);
      rd_req_valid = 1'b1;
    end else begin
      s_rd_addr = S_AW'(v.addr);
      s_rd_req_valid = 1'b1;
    end
    #1;
    check({tag, "_req_ready"}, 64'(v.sel ? s_rd_req_ready : rd_req_ready), 64'(1));
    tick();
    rd_req_valid   = 1'b0;
    s_rd_req_valid = 1'b0;
    check({tag, "_rsp_valid"}, 64'(v.sel ? s_rd_rsp_valid : rd_rsp_valid), 64'(1));
    check({tag, "_rsp_data"}, 64'(v.sel ? s_rd_rsp_data : rd_rsp_data), 64'(v.data));
    check({tag, "_rsp_err"}, 64'(v.sel ? s_rd_rsp_err : rd_rsp_err), 64'(v.err));
    tick();
    check({tag, "_rsp_pulse_end"}, 64'(v.sel ? s_rd_rsp_valid : rd_rsp_valid), 64'(0));
    check({tag, "_rsp_data_hold"}, 64'(v.sel ? s_rd_rsp_data : rd_rsp_data), 64'(v.data));
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[i]) if (vecs[i].phase == p) do_read(vecs[i]);
  endtask

  initial begin
    vecs.push_back('{0, 0, 0,   DW'(0),    1'b0});
    vecs.push_back('{0, 0, 255, DW'(255),  1'b0});
    vecs.push_back('{0, 0, 511, DW'(511),  1'b0});
    vecs.push_back('{1, 1, 6,   DW'(0),    1'b1});
    vecs.push_back('{1, 1, 3,   DW'(13),   1'b0});
    vecs.push_back('{1, 1, 7,   DW'(0),    1'b1});
    vecs.push_back('{1, 1, 0,   DW'(10),   1'b0});
    vecs.push_back('{1, 1, 5,   DW'(15),   1'b0});
    vecs.push_back('{2, 0, 7,   DW'(-7),   1'b0});
    vecs.push_back('{2, 0, 0,   DW'(0),    1'b0});
    vecs.push_back('{2, 0, 511, DW'(-511), 1'b0});
    vecs.push_back('{3, 0, 7,   DW'(7),    1'b0});
    vecs.push_back('{3, 0, 100, DW'(100),  1'b0});
    vecs.push_back('{3, 0, 511, DW'(511),  1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", main_outs(), 64'(0));
    check("reset_outputs_small", small_outs(), 64'(0));
    rst_n = 1'b1;
    tick();
    check("idle_outputs", main_outs(), 64'(0));

    start_pulse();
    run_load(1'b0, DEPTH, -1);
    run_phase(0);

    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 40 && !s_lut_valid; i++) tick();
    check("small_load_done", 64'(s_lut_valid), 64'(1));
    run_phase(1);

    // restart while a read is accepted in the same cycle
    rd_addr      = AW'(7);
    rd_req_valid = 1'b1;
    start        = 1'b1;
    #1;
    check("restart_req_ready", 64'(rd_req_ready), 64'(1));
    tick();
    start        = 1'b0;
    rd_req_valid = 1'b0;
    check("restart_inflight_rsp", 64'({rd_rsp_valid, rd_rsp_err, rd_rsp_data}), 64'({1'b1, 1'b0, DW'(7)}));
    check("restart_state", 64'({lut_valid, busy, load_ready}), 64'(3'b011));
    run_load(1'b1, DEPTH, -1);
    run_phase(2);

    // reset in the middle of a load, then a full reload with an ignored start_i
    start_pulse();
    run_load(1'b0, 100, -1);
    rst_n = 1'b0;
    #1;
    check("midload_reset_outputs", main_outs(), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", main_outs(), 64'(0));
    start_pulse();
    run_load(1'b0, DEPTH, 50);
    run_phase(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
